// File: rtl/multicycle_controller_if.sv
// Memory handshake between the multicycle controller and the memory port.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_src, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_src, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32-style control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// illegal-opcode and memory-timeout traps.
module multicycle_controller #(
  parameter int unsigned INSTRUCTION_LEN = 32,
  parameter int unsigned MEM_TIMEOUT     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INSTRUCTION_LEN-1:0] instruction,
  input  logic                       branch_taken,
  multicycle_controller_if.master    mem,
  output logic [2:0]                 state,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic                       pc_src,
  output logic                       alu_to_pc,
  output logic [1:0]                 alu_op,
  output logic                       alu_src,
  output logic                       pc_to_alu,
  output logic                       reg_write,
  output logic [1:0]                 wb_sel,
  output logic                       retire,
  output logic                       trap,
  output logic [1:0]                 trap_cause
);

  localparam int unsigned     CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_BUS = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_q;
  logic             active_q;
  logic             mem_req_c;
  logic             mem_we_c;
  logic             mem_addr_src_c;

  logic [6:0] opcode;
  logic       is_load, is_store, is_branch, legal, timeout;
  logic       instr_unused;

  assign opcode       = instruction[6:0];
  assign instr_unused = ^instruction[INSTRUCTION_LEN-1:7];
  assign is_load      = (opcode == OP_LOAD);
  assign is_store     = (opcode == OP_STORE);
  assign is_branch    = (opcode == OP_BRANCH);
  assign legal        = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                       OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
  assign timeout      = (wait_cnt == CNT_LAST);

  // active_q holds off the first memory request until the first clock after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      cause_q  <= 2'b00;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      wait_cnt <= '0;
      case (state_q)
        S_FETCH: begin
          if (active_q) begin
            if (mem.mem_ready) begin
              state_q <= S_DECODE;
            end else if (timeout) begin
              state_q <= S_TRAP;
              cause_q <= CAUSE_BUS;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
        end
        S_DECODE: begin
          if (legal) begin
            state_q <= S_EXECUTE;
          end else begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_ILL;
          end
        end
        S_EXECUTE: begin
          if (is_load || is_store) state_q <= S_MEM;
          else if (is_branch)      state_q <= S_FETCH;
          else                     state_q <= S_WRITEBACK;
        end
        S_MEM: begin
          if (mem.mem_ready) begin
            state_q <= is_store ? S_FETCH : S_WRITEBACK;
          end else if (timeout) begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_BUS;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WRITEBACK: state_q <= S_FETCH;
        S_TRAP:      state_q <= S_TRAP;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  // Output decode: datapath controls follow the opcode while an instruction is in flight
  always_comb begin
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 1'b0;
    alu_to_pc      = 1'b0;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_src_c = 1'b0;
    alu_op         = 2'b00;
    alu_src        = 1'b0;
    pc_to_alu      = 1'b0;
    reg_write      = 1'b0;
    wb_sel         = 2'b00;
    retire         = 1'b0;
    trap           = 1'b0;

    if (state_q inside {S_EXECUTE, S_MEM, S_WRITEBACK}) begin
      case (opcode)
        OP_R:               alu_op = 2'b10;
        OP_I:    begin alu_op = 2'b10; alu_src = 1'b1; end
        OP_LOAD, OP_STORE:  alu_src = 1'b1;
        OP_BRANCH:          alu_op = 2'b01;
        OP_AUIPC: begin alu_src = 1'b1; pc_to_alu = 1'b1; end
        OP_JALR:            alu_src = 1'b1;
        default:            alu_op = 2'b00;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        mem_req_c = active_q;
        ir_write  = active_q & mem.mem_ready;
      end
      S_EXECUTE: begin
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken;
          retire   = 1'b1;
        end
      end
      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_src_c = 1'b1;
        mem_we_c       = is_store;
        if (is_store && mem.mem_ready) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      S_WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        pc_src    = (opcode == OP_JAL) || (opcode == OP_JALR);
        alu_to_pc = (opcode == OP_JALR);
        if (is_load)                                     wb_sel = 2'b01;
        else if ((opcode == OP_JAL) || (opcode == OP_JALR)) wb_sel = 2'b10;
        else if (opcode == OP_LUI)                       wb_sel = 2'b11;
        else                                             wb_sel = 2'b00;
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  assign state            = state_q;
  assign trap_cause       = cause_q;
  assign mem.mem_req      = mem_req_c;
  assign mem.mem_we       = mem_we_c;
  assign mem.mem_addr_src = mem_addr_src_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors
// are queued as stimulus is applied and compared against the DUT outputs.
module tb_multicycle_controller;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] cur_ins;
  logic        branch_taken;
  logic [2:0]  state;
  logic        ir_write, pc_write, pc_src, alu_to_pc, alu_src, pc_to_alu;
  logic        reg_write, retire, trap;
  logic [1:0]  alu_op, wb_sel, trap_cause;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  logic [20:0] F_RDY, F_WAIT, DEC, ZERO;

  multicycle_controller_if mif ();

  multicycle_controller #(.INSTRUCTION_LEN(32), .MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .branch_taken (branch_taken),
    .mem          (mif),
    .state        (state),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_to_pc    (alu_to_pc),
    .alu_op       (alu_op),
    .alu_src      (alu_src),
    .pc_to_alu    (pc_to_alu),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [20:0] pk(
    input logic [2:0] st, input logic ir, input logic mreq, input logic mwe,
    input logic mas, input logic pcw, input logic pcs, input logic atp,
    input logic [1:0] aluop, input logic alusrc, input logic ptoa, input logic regw,
    input logic [1:0] wbsel, input logic ret, input logic trp, input logic [1:0] cause);
    return {st, ir, mreq, mwe, mas, pcw, pcs, atp, aluop, alusrc, ptoa, regw,
            wbsel, ret, trp, cause};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {state, ir_write, mif.mem_req, mif.mem_we, mif.mem_addr_src, pc_write,
            pc_src, alu_to_pc, alu_op, alu_src, pc_to_alu, reg_write, wb_sel,
            retire, trap, trap_cause};
  endfunction

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, queue the expectation, compare
  task automatic cyc(input string tag, input logic rdy, input logic bt, input logic [20:0] e);
    @(negedge clk);
    instruction   = cur_ins;
    mif.mem_ready = rdy;
    branch_taken  = bt;
    exp_q.push_back(e);
    #1;
    check(tag, obs_vec(), exp_q.pop_front());
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(tag, obs_vec(), ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    cyc({tag, "_fetch"}, 1'b0, 1'b0, F_WAIT);
  endtask

  initial begin
    F_RDY  = pk(3'd0, I, I, O, O, O, O, O, 2'b00, O, O, O, 2'b00, O, O, 2'b00);
    F_WAIT = pk(3'd0, O, I, O, O, O, O, O, 2'b00, O, O, O, 2'b00, O, O, 2'b00);
    DEC    = pk(3'd1, O, O, O, O, O, O, O, 2'b00, O, O, O, 2'b00, O, O, 2'b00);
    ZERO   = pk(3'd0, O, O, O, O, O, O, O, 2'b00, O, O, O, 2'b00, O, O, 2'b00);

    rst_n = 1'b0; mif.mem_ready = 1'b0; branch_taken = 1'b0;
    cur_ins = 32'h0; instruction = 32'h0;
    #3;
    check("reset", obs_vec(), ZERO);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // R-type add; mem_ready held high everywhere must be ignored outside FETCH
    cur_ins = 32'h002081B3;
    cyc("r_fetch", I, O, F_RDY);
    cyc("r_dec",   I, O, DEC);
    cyc("r_exe",   I, O, pk(3'd2, O, O, O, O, O, O, O, 2'b10, O, O, O, 2'b00, O, O, 2'b00));
    cyc("r_wb",    I, O, pk(3'd4, O, O, O, O, I, O, O, 2'b10, O, O, I, 2'b00, I, O, 2'b00));

    // Load with two memory wait cycles
    cur_ins = 32'h00012083;
    cyc("ld_fetch", I, O, F_RDY);
    cyc("ld_dec",   O, O, DEC);
    cyc("ld_exe",   O, O, pk(3'd2, O, O, O, O, O, O, O, 2'b00, I, O, O, 2'b00, O, O, 2'b00));
    for (int k = 0; k < 2; k++)
      cyc("ld_mem_wait", O, O, pk(3'd3, O, I, O, I, O, O, O, 2'b00, I, O, O, 2'b00, O, O, 2'b00));
    cyc("ld_mem_done", I, O, pk(3'd3, O, I, O, I, O, O, O, 2'b00, I, O, O, 2'b00, O, O, 2'b00));
    cyc("ld_wb",       O, O, pk(3'd4, O, O, O, O, I, O, O, 2'b00, I, O, I, 2'b01, I, O, 2'b00));

    // Branch taken, then not taken
    cur_ins = 32'h00208463;
    cyc("bt_fetch", I, O, F_RDY);
    cyc("bt_dec",   O, O, DEC);
    cyc("bt_exe",   O, I, pk(3'd2, O, O, O, O, I, I, O, 2'b01, O, O, O, 2'b00, I, O, 2'b00));
    cyc("bn_fetch", I, O, F_RDY);
    cyc("bn_dec",   O, O, DEC);
    cyc("bn_exe",   O, O, pk(3'd2, O, O, O, O, I, O, O, 2'b01, O, O, O, 2'b00, I, O, 2'b00));

    // Store completing on first MEM cycle
    cur_ins = 32'h00112023;
    cyc("st_fetch", I, O, F_RDY);
    cyc("st_dec",   O, O, DEC);
    cyc("st_exe",   O, O, pk(3'd2, O, O, O, O, O, O, O, 2'b00, I, O, O, 2'b00, O, O, 2'b00));
    cyc("st_mem",   I, O, pk(3'd3, O, I, I, I, I, O, O, 2'b00, I, O, O, 2'b00, I, O, 2'b00));

    // JALR, LUI, AUIPC writeback variants
    cur_ins = 32'h000080E7;
    cyc("jalr_fetch", I, O, F_RDY);
    cyc("jalr_dec",   O, O, DEC);
    cyc("jalr_exe",   O, O, pk(3'd2, O, O, O, O, O, O, O, 2'b00, I, O, O, 2'b00, O, O, 2'b00));
    cyc("jalr_wb",    O, O, pk(3'd4, O, O, O, O, I, I, I, 2'b00, I, O, I, 2'b10, I, O, 2'b00));
    cur_ins = 32'h000012B7;
    cyc("lui_fetch", I, O, F_RDY);
    cyc("lui_dec",   O, O, DEC);
    cyc("lui_exe",   O, O, pk(3'd2, O, O, O, O, O, O, O, 2'b00, O, O, O, 2'b00, O, O, 2'b00));
    cyc("lui_wb",    O, O, pk(3'd4, O, O, O, O, I, O, O, 2'b00, O, O, I, 2'b11, I, O, 2'b00));
    cur_ins = 32'h00000197;
    cyc("auipc_fetch", I, O, F_RDY);
    cyc("auipc_dec",   O, O, DEC);
    cyc("auipc_exe",   O, O, pk(3'd2, O, O, O, O, O, O, O, 2'b00, I, I, O, 2'b00, O, O, 2'b00));
    cyc("auipc_wb",    O, O, pk(3'd4, O, O, O, O, I, O, O, 2'b00, I, I, I, 2'b00, I, O, 2'b00));

    // Fetch ready on the 16th wait cycle: completes normally
    cur_ins = 32'h00100093;
    for (int k = 0; k < 15; k++) cyc("near_wait", O, O, F_WAIT);
    cyc("near_fetch", I, O, F_RDY);
    cyc("near_dec",   O, O, DEC);
    cyc("near_exe",   O, O, pk(3'd2, O, O, O, O, O, O, O, 2'b10, I, O, O, 2'b00, O, O, 2'b00));
    cyc("near_wb",    O, O, pk(3'd4, O, O, O, O, I, O, O, 2'b10, I, O, I, 2'b00, I, O, 2'b00));

    // Reset asserted while a store waits in MEM
    cur_ins = 32'h00112023;
    cyc("sr_fetch", I, O, F_RDY);
    cyc("sr_dec",   O, O, DEC);
    cyc("sr_exe",   O, O, pk(3'd2, O, O, O, O, O, O, O, 2'b00, I, O, O, 2'b00, O, O, 2'b00));
    cyc("sr_mem",   O, O, pk(3'd3, O, I, I, I, O, O, O, 2'b00, I, O, O, 2'b00, O, O, 2'b00));
    pulse_reset("sr_rst");

    // Illegal opcode traps and holds regardless of mem_ready
    cur_ins = 32'h0000007F;
    cyc("ill_fetch", I, O, F_RDY);
    cyc("ill_dec",   I, O, DEC);
    for (int k = 0; k < 3; k++)
      cyc("ill_trap", (k % 2 == 0) ? I : O, O,
          pk(3'd5, O, O, O, O, O, O, O, 2'b00, O, O, O, 2'b00, O, I, 2'b01));
    pulse_reset("ill_rst");

    // Fetch timeout: 16 wait cycles then bus-error trap (one wait already spent above)
    cur_ins = 32'h002081B3;
    for (int k = 0; k < 15; k++) cyc("to_wait", O, O, F_WAIT);
    for (int k = 0; k < 2; k++)
      cyc("to_trap", O, O, pk(3'd5, O, O, O, O, O, O, O, 2'b00, O, O, O, 2'b00, O, I, 2'b10));
    pulse_reset("to_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter INSTRUCTION_LEN, default 32, instruction word width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, maximum memory-wait cycles before a bus-error trap.
REQ-003 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- instruction  in  INSTRUCTION_LEN  IR contents; opcode = instruction[6:0]; stable from DECODE onward.
- mem_ready  in  1  memory completes the current mem_req this cycle.
- branch_taken  in  1  datapath branch-compare result.
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC this cycle.
- pc_src  out  1  0 = PC+4, 1 = branch/jump target.
- alu_to_pc  out  1  PC target comes from ALU (JALR).
- mem_req  out  1  memory access request.
- mem_we  out  1  write access (store).
- mem_addr_src  out  1  0 = PC, 1 = ALU result.
- alu_op  out  2  00 add, 01 compare, 10 funct-decoded.
- alu_src  out  1  0 = rs2, 1 = immediate.
- pc_to_alu  out  1  ALU operand A = PC.
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4, 11 immediate.
- retire  out  1  one-cycle pulse per completed instruction.
- trap  out  1  controller halted in TRAP.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout.

Function
REQ-004 SHALL be a Moore/Mealy FSM in which every output not listed as asserted in a state is 0.
REQ-005 FETCH SHALL assert mem_req with mem_addr_src=0 and mem_we=0; on mem_ready SHALL pulse ir_write and move to DECODE, else stay.
REQ-006 DECODE SHALL last exactly 1 cycle: legal opcode (51, 19, 3, 35, 99, 55, 23, 111, 103) -> EXECUTE; any other -> TRAP with cause 01.
REQ-007 alu_op/alu_src/pc_to_alu SHALL be driven from the opcode in EXECUTE, MEM and WRITEBACK: 51 {10,0,0}; 19 {10,1,0}; 3/35 {00,1,0}; 99 {01,0,0}; 23 {00,1,1}; 103 {00,1,0}; 55/111 {00,0,0}.
REQ-008 EXECUTE SHALL last 1 cycle: opcodes 3/35 -> MEM; opcode 99 -> assert pc_write, pc_src=branch_taken, pulse retire, -> FETCH; all others -> WRITEBACK.
REQ-009 MEM SHALL assert mem_req with mem_addr_src=1 and mem_we=1 only for opcode 35; on mem_ready a load moves to WRITEBACK, and a store asserts pc_write (pc_src=0), pulses retire and moves to FETCH.
REQ-010 WRITEBACK SHALL last 1 cycle, assert reg_write, pc_write and retire, then move to FETCH; wb_sel: 3 -> 01, 111/103 -> 10, 55 -> 11, others -> 00; pc_src=1 for 111/103, else 0; alu_to_pc=1 only for 103.
REQ-011 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_req is high with mem_ready low.
REQ-012 When the wait counter reaches MEM_TIMEOUT with mem_ready still low, the FSM SHALL move to TRAP with cause 10 instead of waiting further.
REQ-013 mem_ready on the same cycle the counter reaches MEM_TIMEOUT SHALL take priority (normal completion, no trap).
REQ-014 TRAP SHALL hold trap=1 and trap_cause stable, with all other outputs 0, until reset.
REQ-015 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-016 Latency: R/I-ALU/LUI/AUIPC/JAL/JALR 4 cycles, branch 3, store 4, load 5, plus memory wait cycles.

Reset
REQ-017 rst_n low SHALL asynchronously force state=FETCH, wait counter=0, trap_cause=00, and all outputs except state to 0 for the duration of reset.
REQ-018 Reset asserted mid-access (FETCH/MEM) SHALL abandon the access; after release the FSM starts in FETCH with mem_req=1 on the first cycle.

Verification
REQ-019 R-type 0x002081B3, mem_ready=1 every FETCH -> states 0,1,2,4,0; reg_write=1, wb_sel=00, pc_write=1 and retire=1 only in WRITEBACK.
REQ-020 Load opcode 3, mem_ready low 2 cycles in MEM -> MEM lasts 3 cycles, mem_addr_src=1, mem_we=0, then WRITEBACK with wb_sel=01.
REQ-021 Branch opcode 99 with branch_taken=1 -> EXECUTE asserts pc_write=1, pc_src=1, alu_op=01, retire=1; next state FETCH; reg_write stays 0.
REQ-022 Opcode 0x7F -> DECODE goes to TRAP; trap=1, trap_cause=01; FSM stays in TRAP with mem_req=0 until rst_n low.
REQ-023 mem_ready held low in FETCH -> TRAP with trap_cause=10 after exactly 16 wait cycles; a repeat run with mem_ready=1 on the 16th wait cycle -> DECODE, no trap.
REQ-024 rst_n pulsed low during MEM of a store -> outputs 0 immediately; after release state=0, mem_req=1, mem_we=0.
